alarm_clock: RTL and testbench

- 24-hour BCD time-of-day clock with a settable alarm and latched alert output.
- Front-panel controls: `mode` selects run / set-time / set-alarm; `turn` selects the hour or minute field; each rising edge of `change` increments the selected field; `reset1` acknowledges the alarm.
- Sits between a one-second tick source (internal prescaler) and a 7-segment display driver.

---
 rtl/alarm_clock_pkg.sv | 19 +
 rtl/alarm_clock_bcd_counter.sv | 36 +++
 rtl/alarm_clock.sv | 100 ++++++++++
 tb/tb_alarm_clock.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared types, mode encodings and BCD limits for the alarm clock.
// Optional hourly chime is enabled by defining HOURLY_CHIME_EN.
package alarm_clock_pkg;
  typedef logic [7:0] bcd8_t;

  localparam logic [1:0] MODE_RUN       = 2'd0;
  localparam logic [1:0] MODE_SET_TIME  = 2'd1;
  localparam logic [1:0] MODE_SET_ALARM = 2'd2;

  localparam bcd8_t SEC_MAX  = 8'h59;
  localparam bcd8_t MIN_MAX  = 8'h59;
  localparam bcd8_t HOUR_MAX = 8'h23;

  // Two-digit BCD increment without range wrap; the caller handles MAX.
  function automatic bcd8_t bcd_inc(input bcd8_t v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/alarm_clock_bcd_counter.sv
// Two-digit BCD counter that wraps from MAX to 00 and flags the carry.
module bcd_counter
  import alarm_clock_pkg::*;
#(
  parameter bcd8_t MAX = SEC_MAX
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  output bcd8_t value,
  output bcd8_t next,
  output logic  carry
);
  bcd8_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    carry   = 1'b0;
    if (inc) begin
      if (value_q == MAX) begin
        value_d = '0;
        carry   = 1'b1;
      end else begin
        value_d = bcd_inc(value_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;
  assign next  = value_d;
endmodule

// File: rtl/alarm_clock.sv
// 24-hour BCD clock with settable alarm and latched alert.
// Define HOURLY_CHIME_EN to add a one-cycle chime output at every HH:00:00.
module alarm_clock
  import alarm_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       turn,
  input  logic       change,
  input  logic       reset1,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       alert
`ifdef HOURLY_CHIME_EN
  ,
  output logic       chime
`endif
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic chg_q, chg_d;
  logic alert_q, alert_d;
  logic set_time, set_alarm, tick, pulse, match;
  logic sec_carry, min_carry, hr_carry, amin_carry, ahr_carry;
  logic min_inc, hr_inc, amin_inc, ahr_inc;
  bcd8_t sec_v, min_v, hr_v, amin_v, ahr_v;
  bcd8_t sec_n, min_n, hr_n, amin_n, ahr_n;

  assign set_time  = (mode == MODE_SET_TIME);
  assign set_alarm = (mode == MODE_SET_ALARM);

  // Prescaler freezes together with timekeeping while the time is being set.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (!set_time) begin
      if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    chg_d    = change;
    pulse    = change & ~chg_q;
    min_inc  = set_time ? (pulse & ~turn) : sec_carry;
    hr_inc   = set_time ? (pulse & turn)  : min_carry;
    amin_inc = set_alarm & pulse & ~turn;
    ahr_inc  = set_alarm & pulse & turn;
    // Compare against the alarm as it stood before any same-cycle edit.
    match    = tick && (sec_n == 8'h00) && (min_n == amin_v) && (hr_n == ahr_v);
    alert_d  = reset1 ? 1'b0 : (match ? 1'b1 : alert_q);
  end

  bcd_counter #(.MAX(SEC_MAX))  u_sec  (.clk(clk), .rst(reset), .inc(tick),     .value(sec_v),  .next(sec_n),  .carry(sec_carry));
  bcd_counter #(.MAX(MIN_MAX))  u_min  (.clk(clk), .rst(reset), .inc(min_inc),  .value(min_v),  .next(min_n),  .carry(min_carry));
  bcd_counter #(.MAX(HOUR_MAX)) u_hr   (.clk(clk), .rst(reset), .inc(hr_inc),   .value(hr_v),   .next(hr_n),   .carry(hr_carry));
  bcd_counter #(.MAX(MIN_MAX))  u_amin (.clk(clk), .rst(reset), .inc(amin_inc), .value(amin_v), .next(amin_n), .carry(amin_carry));
  bcd_counter #(.MAX(HOUR_MAX)) u_ahr  (.clk(clk), .rst(reset), .inc(ahr_inc),  .value(ahr_v),  .next(ahr_n),  .carry(ahr_carry));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      chg_q   <= 1'b0;
      alert_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      chg_q   <= chg_d;
      alert_q <= alert_d;
    end
  end

`ifdef HOURLY_CHIME_EN
  logic chime_q, chime_d;
  assign chime_d = tick & min_carry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) chime_q <= 1'b0;
    else       chime_q <= chime_d;
  end

  assign chime = chime_q;
`endif

  always_comb begin
    hour   = set_alarm ? ahr_v  : hr_v;
    minute = set_alarm ? amin_v : min_v;
    second = set_alarm ? 8'h00  : sec_v;
  end

  assign alert = alert_q;
endmodule

// File: tb/tb_alarm_clock.sv
// Directed bench for alarm_clock: decimal reference model plus fixed
// expectations, queued as a scoreboard and compared at the falling edge.
module tb_alarm_clock;
  logic       clk = 1'b0;
  logic       reset, turn, change, reset1;
  logic [1:0] mode;
  logic [7:0] hour, minute, second;
  logic       alert;
`ifdef HOURLY_CHIME_EN
  logic       chime;
`endif

  alarm_clock #(.TICKS_PER_SEC(1)) dut (
    .clk(clk), .reset(reset), .mode(mode), .turn(turn), .change(change),
    .reset1(reset1), .hour(hour), .minute(minute), .second(second), .alert(alert)
`ifdef HOURLY_CHIME_EN
    , .chime(chime)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] h, m, s;
    logic       a;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int th, tm, ts, ah, am;
  bit mchg, malert;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    th = 0; tm = 0; ts = 0; ah = 0; am = 0; mchg = 0; malert = 0;
  endtask

  task automatic model_edge();
    int mv;
    bit p, match;
    mv    = (mode == 2'd3) ? 0 : int'(mode);
    p     = change && !mchg;
    mchg  = change;
    match = 0;
    if (mv == 1) begin
      if (p) begin
        if (turn) th = (th + 1) % 24;
        else      tm = (tm + 1) % 60;
      end
    end else begin
      ts++;
      if (ts == 60) begin
        ts = 0; tm++;
        if (tm == 60) begin
          tm = 0; th = (th + 1) % 24;
        end
      end
      match = (th == ah) && (tm == am) && (ts == 0);
      if (mv == 2 && p) begin
        if (turn) ah = (ah + 1) % 24;
        else      am = (am + 1) % 60;
      end
    end
    if (reset1)     malert = 0;
    else if (match) malert = 1;
  endtask

  task automatic push_model(input string tag);
    exp_t e;
    e.tag = tag;
    if (mode == 2'd2) begin
      e.h = bcd(ah); e.m = bcd(am); e.s = 8'h00;
    end else begin
      e.h = bcd(th); e.m = bcd(tm); e.s = bcd(ts);
    end
    e.a = malert;
    sb.push_back(e);
  endtask

  task automatic push_const(input string tag, input logic [7:0] h, m, s, input logic a);
    exp_t e;
    e.tag = tag; e.h = h; e.m = m; e.s = s; e.a = a;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got 0 entries required 1");
    end else begin
      e = sb.pop_front();
      assert (hour === e.h) else begin
        errors++; $error("FAIL %s hour got %h required %h", e.tag, hour, e.h);
      end
      checks++;
      assert (minute === e.m) else begin
        errors++; $error("FAIL %s minute got %h required %h", e.tag, minute, e.m);
      end
      checks++;
      assert (second === e.s) else begin
        errors++; $error("FAIL %s second got %h required %h", e.tag, second, e.s);
      end
      checks++;
      assert (alert === e.a) else begin
        errors++; $error("FAIL %s alert got %b required %b", e.tag, alert, e.a);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step_chk(input string tag);
    step();
    push_model(tag);
    check_pop();
  endtask

  task automatic pulse_chk(input string tag);
    change = 1'b1; step_chk(tag);
    change = 1'b0; step_chk(tag);
  endtask

  task automatic pulse();
    change = 1'b1; step();
    change = 1'b0; step();
  endtask

  initial begin
    reset = 1'b1; mode = 2'd0; turn = 1'b0; change = 1'b0; reset1 = 1'b0;
    model_reset();
    #12;
    push_const("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    check_pop();
    @(negedge clk);
    reset = 1'b0;

    repeat (60) step();
    push_const("run60", 8'h00, 8'h01, 8'h00, 1'b0);
    check_pop();

    // Set time: seconds must stay frozen at 00 throughout.
    mode = 2'd1; turn = 1'b1;
    step_chk("enter_set");
    pulse_chk("hour_pulse");
    pulse_chk("hour_pulse");
    push_const("hour_plus2", 8'h02, 8'h01, 8'h00, 1'b0);
    check_pop();

    turn = 1'b0;
    repeat (58) pulse();
    push_const("min59", 8'h02, 8'h59, 8'h00, 1'b0);
    check_pop();
    pulse();
    push_const("min_wrap", 8'h02, 8'h00, 8'h00, 1'b0);
    check_pop();

    turn = 1'b1;
    repeat (21) pulse();
    push_const("hour23", 8'h23, 8'h00, 8'h00, 1'b0);
    check_pop();
    pulse();
    push_const("hour_wrap", 8'h00, 8'h00, 8'h00, 1'b0);
    check_pop();

    turn = 1'b0; change = 1'b1;
    repeat (5) step();
    change = 1'b0;
    step_chk("hold5_model");
    push_const("hold5", 8'h00, 8'h01, 8'h00, 1'b0);
    check_pop();

    // Set alarm to 03:02 while the time keeps running.
    mode = 2'd2;
    step();
    turn = 1'b1;
    repeat (3) pulse();
    turn = 1'b0;
    repeat (2) pulse();
    push_const("alarm_disp", 8'h03, 8'h02, 8'h00, 1'b0);
    check_pop();
    mode = 2'd0;
    step_chk("back_run_model");
    push_const("back_run", 8'h00, 8'h01, 8'h12, 1'b0);
    check_pop();

    reset1 = 1'b1; step(); reset1 = 1'b0;
    mode = 2'd1; turn = 1'b1;
    repeat (3) pulse();
    mode = 2'd0;
    for (int i = 0; i < 70 && ts != 50; i++) step();
    push_const("pre_alarm", 8'h03, 8'h01, 8'h50, 1'b0);
    check_pop();

    for (int i = 1; i <= 10; i++) begin
      step_chk("alarm_run");
      if (i == 9) begin
        push_const("before_match", 8'h03, 8'h01, 8'h59, 1'b0);
        check_pop();
      end
    end
    push_const("alert_rise", 8'h03, 8'h02, 8'h00, 1'b1);
    check_pop();
    step();
    push_const("alert_hold", 8'h03, 8'h02, 8'h01, 1'b1);
    check_pop();
    reset1 = 1'b1;
    step();
    push_const("alert_ack", 8'h03, 8'h02, 8'h02, 1'b0);
    check_pop();
    reset1 = 1'b0;
    step_chk("after_ack");

    // Asynchronous reset between clock edges.
    repeat (7) step();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    push_const("async_rst", 8'h00, 8'h00, 8'h00, 1'b0);
    check_pop();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step_chk("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
